// File: rtl/adder_pkg.sv
// Shared constants, types and flag helper for the registered 32-bit CLA adder.
package adder_pkg;

    localparam int WIDTH = 32;
    localparam int BLK   = 4;
    localparam int NGRP  = WIDTH / BLK;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [NGRP-1:0]  grp_t;

    // Signed overflow: operands agree in sign but the sum's sign differs.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder32_cla_4.sv
// 4-bit carry-lookahead slice: local sum plus group propagate/generate for the next level.
module cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       p,
    output logic       g
);

    logic [3:0] pb;
    logic [3:0] gb;
    logic [3:0] c;

    assign pb = a ^ b;
    assign gb = a & b;

    assign c[0] = cin;
    assign c[1] = gb[0] | (pb[0] & cin);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                | (pb[2] & pb[1] & pb[0] & cin);

    assign s = pb ^ c;

    // Group terms are independent of cin so the upper lookahead level never loops back.
    assign p = &pb;
    assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);

endmodule

// File: rtl/adder32.sv
// Registered 32-bit two's-complement adder, 1-cycle latency, valid-qualified.
// Optional subtract mode (extra `sub` port) is enabled by defining ADDER_SUB_EN.
module adder32
    import adder_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  word_t a,
    input  word_t b,
    input  logic  cin,
`ifdef ADDER_SUB_EN
    input  logic  sub,
`endif
    output word_t q,
    output logic  cout,
    output logic  ovf,
    output logic  out_valid
);

    word_t           b_eff;
    logic            cin_eff;
    word_t           sum;
    grp_t            grp_p;
    grp_t            grp_g;
    logic [NGRP:0]   grp_c;

`ifdef ADDER_SUB_EN
    // Subtract as a + ~b + ~cin, so cin acts as borrow-in and cout=1 means no borrow.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~cin : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    for (genvar i = 0; i < NGRP; i++) begin : g_slice
        cla_4 u_cla (
            .a   (a[i*BLK +: BLK]),
            .b   (b_eff[i*BLK +: BLK]),
            .cin (grp_c[i]),
            .s   (sum[i*BLK +: BLK]),
            .p   (grp_p[i]),
            .g   (grp_g[i])
        );
    end

    // Second-level lookahead: each group carry as a flat sum of products of group P/G.
    always_comb begin
        logic prod;
        logic acc;
        grp_c[0] = cin_eff;
        for (int k = 1; k <= NGRP; k++) begin
            acc  = 1'b0;
            for (int j = 0; j < k; j++) begin
                prod = grp_g[j];
                for (int m = j + 1; m < k; m++) prod = prod & grp_p[m];
                acc = acc | prod;
            end
            prod = cin_eff;
            for (int m = 0; m < k; m++) prod = prod & grp_p[m];
            grp_c[k] = acc | prod;
        end
    end

    word_t q_d,    q_q;
    logic  cout_d, cout_q;
    logic  ovf_d,  ovf_q;
    logic  vld_d,  vld_q;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        q_d    = q_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        vld_d  = in_valid;
        if (in_valid) begin
            q_d    = sum;
            cout_d = grp_c[NGRP];
            ovf_d  = ovf_calc(a[WIDTH-1], b_eff[WIDTH-1], sum[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            q_q    <= q_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    assign q         = q_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_adder32.sv
// Directed self-checking bench for adder32; subtract vectors run when ADDER_SUB_EN is defined.
module tb_adder32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
`ifdef ADDER_SUB_EN
    logic        sub;
`endif
    logic [31:0] q;
    logic        cout;
    logic        ovf;
    logic        out_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    adder32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER_SUB_EN
        .sub       (sub),
`endif
        .q         (q),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    // Drive on the falling edge, then sample 1ns after the next rising edge.
    task automatic drive(input logic v, input logic [31:0] va, input logic [31:0] vb, input logic vc);
        @(negedge clk);
        in_valid = v;
        a        = va;
        b        = vb;
        cin      = vc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [31:0] eq, input logic ec,
                              input logic eo, input logic ev);
        total_cnt++;
        if (q !== eq || cout !== ec || ovf !== eo || out_valid !== ev)
            $display("FAIL %s: got q=%h cout=%b ovf=%b vld=%b, want q=%h cout=%b ovf=%b vld=%b",
                     name, q, cout, ovf, out_valid, eq, ec, eo, ev);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
`ifdef ADDER_SUB_EN
        sub      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_state", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_add();
        drive(1'b1, 32'd1209, 32'd4565, 1'b0);
        expect_out("basic_add", 32'h0000168E, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_unsigned_wrap();
        drive(1'b1, 32'hFFFFFFFF, 32'h1, 1'b0);
        expect_out("unsigned_wrap", 32'h0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_signed_ovf();
        drive(1'b1, 32'h7FFFFFFF, 32'h1, 1'b0);
        expect_out("ovf_pos", 32'h80000000, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h80000000, 32'h80000000, 1'b0);
        expect_out("ovf_neg", 32'h0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_cin_hold();
        drive(1'b1, 32'h0, 32'h0, 1'b1);
        expect_out("cin_only", 32'h1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'hDEADBEEF, 32'h12345678, 1'b1);
        expect_out("hold_invalid", 32'h1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'hxxxxxxxx, 32'hxxxxxxxx, 1'bx);
        expect_out("hold_x_inputs", 32'h1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h12345678, 32'h11111111, 1'b0);
        expect_out("b2b_0", 32'h23456789, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        expect_out("b2b_1", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b1);
        expect_out("b2b_full_propagate", 32'h0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h0000FFFF, 32'h00000001, 1'b0);
        expect_out("b2b_group_carry", 32'h00010000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        expect_out("b2b_all_ones_cin", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 32'd100, 32'd23, 1'b0);
        expect_out("pre_reset", 32'd123, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'd5, 32'd6, 1'b0);
        expect_out("post_reset_sample", 32'd11, 1'b0, 1'b0, 1'b1);
    endtask

`ifdef ADDER_SUB_EN
    task automatic test_sub();
        @(negedge clk);
        sub = 1'b1;
        drive(1'b1, 32'd10, 32'd3, 1'b0);
        expect_out("sub_pos", 32'd7, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'd3, 32'd10, 1'b0);
        expect_out("sub_neg", 32'hFFFFFFF9, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'd10, 32'd3, 1'b1);
        expect_out("sub_borrow_in", 32'd6, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h80000000, 32'h1, 1'b0);
        expect_out("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_add();
        test_unsigned_wrap();
        test_signed_ovf();
        test_cin_hold();
        test_back_to_back();
        test_reset_midstream();
`ifdef ADDER_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
